// File: rtl/width_gearbox_pkg.sv
// Shared types and width helpers for the width_gearbox bus-width converter.
package width_gearbox_pkg;

    typedef enum logic {
        STREAM = 1'b0,
        DRAIN  = 1'b1
    } gb_state_t;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int cnt_w(input int in_w, input int out_w);
        return $clog2(in_w + out_w + 1);
    endfunction

    function automatic int nb_w(input int out_w);
        return $clog2(out_w + 1);
    endfunction

endpackage

// File: rtl/gearbox_shift_buf.sv
// Bit buffer with a fill count: pop-by-n shifts down, then push appends at the
// resulting fill offset. Bits at and above cnt are always zero.
module gearbox_shift_buf
    import width_gearbox_pkg::*;
#(
    parameter int IN  = 12,
    parameter int OUT = 25,
    localparam int BW = IN + OUT,
    localparam int CW = cnt_w(IN, OUT),
    localparam int NW = nb_w(OUT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [IN-1:0] data,
    input  logic          pop,
    input  logic [NW-1:0] nbits,
    output logic [OUT-1:0] head,
    output logic [CW-1:0] cnt
);

    logic [BW-1:0] bits;
    logic [BW-1:0] bits_pop;
    logic [BW-1:0] ins;
    logic [CW-1:0] cnt_pop;

    always_comb begin
        cnt_pop  = pop ? cnt - CW'(nbits) : cnt;
        bits_pop = pop ? bits >> nbits : bits;
        ins      = BW'(data) << cnt_pop;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bits <= '0;
            cnt  <= '0;
        end else begin
            bits <= push ? (bits_pop | ins) : bits_pop;
            cnt  <= push ? cnt_pop + CW'(IN) : cnt_pop;
        end
    end

    assign head = bits[OUT-1:0];

endmodule

// File: rtl/width_gearbox.sv
// Parametric IN-to-OUT bit-stream width converter with valid/ready on both
// sides and an end-of-packet drain that emits a zero-padded partial word.
module width_gearbox
    import width_gearbox_pkg::*;
#(
    parameter int IN  = 12,
    parameter int OUT = 25
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [IN-1:0]              in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_last,
    output logic [OUT-1:0]             out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [nb_w(OUT)-1:0]       out_nbits,
    output logic [cnt_w(IN, OUT)-1:0]  fill
);

    localparam int CW = cnt_w(IN, OUT);
    localparam int NW = nb_w(OUT);

    if (IN < 1 || OUT < 1) begin : g_bad_param
        $error("width_gearbox: IN and OUT must be >= 1");
    end

    gb_state_t      state;
    gb_state_t      state_nxt;
    logic [OUT-1:0] head;
    logic [OUT-1:0] mask;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_left;
    logic           pop;
    logic           accept;

    gearbox_shift_buf #(
        .IN  (IN),
        .OUT (OUT)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .data  (in_data),
        .pop   (pop),
        .nbits (out_nbits),
        .head  (head),
        .cnt   (cnt)
    );

    // Outputs depend only on registered state; in_ready sees out_ready.
    always_comb begin
        out_nbits = NW'(min_int(int'(cnt), OUT));
        mask      = ~({OUT{1'b1}} << out_nbits);
        out_data  = head & mask;
        out_valid = (cnt >= CW'(OUT)) || (state == DRAIN && cnt != '0);
        out_last  = (state == DRAIN) && (cnt <= CW'(OUT));
        pop       = out_valid && out_ready;
        cnt_left  = pop ? cnt - CW'(out_nbits) : cnt;
        in_ready  = rst_n && (state == STREAM) && (cnt_left <= CW'(OUT));
        accept    = in_valid && in_ready;
        fill      = cnt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            STREAM: if (accept && in_last) state_nxt = DRAIN;
            DRAIN:  if (pop && cnt_left == '0) state_nxt = STREAM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= STREAM;
        else        state <= state_nxt;
    end

endmodule

// File: tb/tb_width_gearbox.sv
// Directed bench for width_gearbox: three instances (12->25, 5->10, 32->8)
// with a bit-queue model for the streaming scenarios.
module tb_width_gearbox;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [11:0] a_in_data;
    logic        a_in_valid, a_in_ready, a_in_last;
    logic [24:0] a_out_data;
    logic        a_out_valid, a_out_ready, a_out_last;
    logic [4:0]  a_out_nbits;
    logic [5:0]  a_fill;

    logic [4:0]  b_in_data;
    logic        b_in_valid, b_in_ready, b_in_last;
    logic [9:0]  b_out_data;
    logic        b_out_valid, b_out_ready, b_out_last;
    logic [3:0]  b_out_nbits;
    logic [3:0]  b_fill;

    logic [31:0] c_in_data;
    logic        c_in_valid, c_in_ready, c_in_last;
    logic [7:0]  c_out_data;
    logic        c_out_valid, c_out_ready, c_out_last;
    logic [3:0]  c_out_nbits;
    logic [5:0]  c_fill;

    width_gearbox #(.IN(12), .OUT(25)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .in_last(a_in_last),
        .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_last(a_out_last),
        .out_nbits(a_out_nbits), .fill(a_fill)
    );

    width_gearbox #(.IN(5), .OUT(10)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .in_last(b_in_last),
        .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_last(b_out_last),
        .out_nbits(b_out_nbits), .fill(b_fill)
    );

    width_gearbox #(.IN(32), .OUT(8)) u_c (
        .clk(clk), .rst_n(rst_n),
        .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .in_last(c_in_last),
        .out_data(c_out_data), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_last(c_out_last),
        .out_nbits(c_out_nbits), .fill(c_fill)
    );

    int checks = 0;
    int errors = 0;
    bit mq[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pop_exp(input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++) r[i] = mq.pop_front();
        return r;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        a_in_data = '1; a_in_valid = 1'b1; a_in_last = 1'b0; a_out_ready = 1'b0;
        b_in_data = '0; b_in_valid = 1'b1; b_in_last = 1'b0; b_out_ready = 1'b0;
        c_in_data = '0; c_in_valid = 1'b1; c_in_last = 1'b0; c_out_ready = 1'b0;
        repeat (2) tick;
        #1;
        checks++;
        if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0 || c_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got %b%b%b want 000",
                     a_in_ready, b_in_ready, c_in_ready);
        end
        checks++;
        if ({a_out_valid, a_out_last, a_out_nbits, a_out_data, a_fill} !== '0) begin
            errors++;
            $display("FAIL reset_outputs v=%b l=%b nb=%0d d=%h fill=%0d want all 0",
                     a_out_valid, a_out_last, a_out_nbits, a_out_data, a_fill);
        end
        checks++;
        if (b_fill !== '0 || c_fill !== '0 || b_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_bc got bfill=%0d cfill=%0d want 0", b_fill, c_fill);
        end
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_stream;
        int k = 0;
        int popped = 0;
        bit first = 0;
        logic [31:0] e;
        logic acc, pp;
        a_out_ready = 1'b1;
        a_in_last = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (k == 100 && a_fill == 0) break;
            a_in_valid = (k < 100);
            a_in_data = 12'(k);
            #1;
            if (k < 100) begin
                checks++;
                if (a_in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_in_ready k=%0d got %b want 1", k, a_in_ready);
                end
            end
            if (k < 3) begin
                checks++;
                if (a_out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_early_valid k=%0d got %b want 0", k, a_out_valid);
                end
            end
            if (k == 3 && !first) begin
                first = 1;
                checks++;
                if (a_out_valid !== 1'b1 || a_out_data !== 25'h0001000 || a_out_nbits !== 5'd25) begin
                    errors++;
                    $display("FAIL stream_first got v=%b d=%h nb=%0d want 1 0001000 25",
                             a_out_valid, a_out_data, a_out_nbits);
                end
            end
            acc = a_in_valid && a_in_ready;
            pp = a_out_valid && a_out_ready;
            if (pp) begin
                e = pop_exp(int'(a_out_nbits));
                checks++;
                if (a_out_data !== e[24:0]) begin
                    errors++;
                    $display("FAIL stream_word got %h want %h", a_out_data, e[24:0]);
                end
                popped += int'(a_out_nbits);
            end
            if (acc) begin
                for (int i = 0; i < 12; i++) mq.push_back(a_in_data[i]);
                k++;
            end
            tick;
        end
        a_in_valid = 1'b0;
        checks++;
        if (popped != 1200 || a_fill !== '0 || mq.size() != 0) begin
            errors++;
            $display("FAIL stream_total got bits=%0d fill=%0d q=%0d want 1200 0 0",
                     popped, a_fill, mq.size());
        end
    endtask

    task automatic test_backpressure;
        int k = 0;
        int popped = 0;
        logic [24:0] held;
        logic [24:0] peek;
        logic [31:0] e;
        logic acc, pp;
        a_out_ready = 1'b0;
        a_in_last = 1'b0;
        a_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in_data = 12'hA00 | 12'(k);
            #1;
            checks++;
            if (a_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL bp_fill_ready i=%0d got %b want 1", i, a_in_ready);
            end
            for (int j = 0; j < 12; j++) mq.push_back(a_in_data[j]);
            k++;
            tick;
        end
        a_in_data = 12'hA00 | 12'(k);
        #1;
        checks++;
        if (a_fill !== 6'd36 || a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got fill=%0d rdy=%b want 36 0", a_fill, a_in_ready);
        end
        for (int i = 0; i < 25; i++) peek[i] = mq[i];
        held = a_out_data;
        checks++;
        if (held !== peek) begin
            errors++;
            $display("FAIL bp_head got %h want %h", held, peek);
        end
        for (int i = 0; i < 10; i++) begin
            tick;
            #1;
            checks++;
            if (a_out_data !== held || a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold c=%0d got d=%h v=%b r=%b want %h 1 0",
                         i, a_out_data, a_out_valid, a_in_ready, held);
            end
        end
        tick;
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (k == 25 && a_fill == 0) break;
            a_in_valid = (k < 25);
            a_in_data = 12'hA00 | 12'(k);
            #1;
            acc = a_in_valid && a_in_ready;
            pp = a_out_valid && a_out_ready;
            if (pp) begin
                e = pop_exp(int'(a_out_nbits));
                checks++;
                if (a_out_data !== e[24:0]) begin
                    errors++;
                    $display("FAIL bp_word got %h want %h", a_out_data, e[24:0]);
                end
                popped += int'(a_out_nbits);
            end
            if (acc) begin
                for (int j = 0; j < 12; j++) mq.push_back(a_in_data[j]);
                k++;
            end
            tick;
        end
        a_in_valid = 1'b0;
        checks++;
        if (popped != 300 || a_fill !== '0 || mq.size() != 0) begin
            errors++;
            $display("FAIL bp_total got bits=%0d fill=%0d q=%0d want 300 0 0",
                     popped, a_fill, mq.size());
        end
    endtask

    task automatic test_packet_end;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in_data = 12'hFFF;
            a_in_valid = 1'b1;
            a_in_last = (i == 2);
            #1;
            tick;
        end
        a_in_valid = 1'b0;
        a_in_last = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 25'h1FFFFFF || a_out_last !== 1'b0
            || a_out_nbits !== 5'd25 || a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL pkt_word1 got v=%b d=%h l=%b nb=%0d r=%b want 1 1ffffff 0 25 0",
                     a_out_valid, a_out_data, a_out_last, a_out_nbits, a_in_ready);
        end
        tick;
        #1;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 25'h00007FF || a_out_last !== 1'b1
            || a_out_nbits !== 5'd11 || a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL pkt_word2 got v=%b d=%h l=%b nb=%0d r=%b want 1 00007ff 1 11 0",
                     a_out_valid, a_out_data, a_out_last, a_out_nbits, a_in_ready);
        end
        tick;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_fill !== '0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL pkt_after got v=%b fill=%0d r=%b want 0 0 1",
                     a_out_valid, a_fill, a_in_ready);
        end
    endtask

    task automatic test_exact_multiple;
        b_out_ready = 1'b1;
        b_in_valid = 1'b1;
        b_in_data = 5'h15;
        b_in_last = 1'b0;
        #1;
        tick;
        b_in_data = 5'h0A;
        b_in_last = 1'b1;
        #1;
        checks++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL exact_mid got v=%b r=%b want 0 1", b_out_valid, b_in_ready);
        end
        tick;
        b_in_valid = 1'b0;
        b_in_last = 1'b0;
        #1;
        checks++;
        if (b_out_valid !== 1'b1 || b_out_nbits !== 4'd10 || b_out_last !== 1'b1
            || b_out_data !== 10'h155) begin
            errors++;
            $display("FAIL exact_word got v=%b nb=%0d l=%b d=%h want 1 10 1 155",
                     b_out_valid, b_out_nbits, b_out_last, b_out_data);
        end
        tick;
        #1;
        checks++;
        if (b_out_valid !== 1'b0 || b_fill !== '0 || b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL exact_after got v=%b fill=%0d r=%b want 0 0 1",
                     b_out_valid, b_fill, b_in_ready);
        end
    endtask

    task automatic test_downsize;
        logic [7:0] eb [4];
        int acc_cyc [$];
        eb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        c_out_ready = 1'b1;
        c_in_data = 32'hDDCCBBAA;
        c_in_valid = 1'b1;
        c_in_last = 1'b1;
        #1;
        tick;
        c_in_valid = 1'b0;
        c_in_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (c_out_valid !== 1'b1 || c_out_data !== eb[i] || c_out_last !== (i == 3)
                || c_out_nbits !== 4'd8) begin
                errors++;
                $display("FAIL down_byte%0d got v=%b d=%h l=%b nb=%0d want 1 %h %b 8",
                         i, c_out_valid, c_out_data, c_out_last, c_out_nbits,
                         eb[i], (i == 3));
            end
            tick;
        end
        #1;
        checks++;
        if (c_out_valid !== 1'b0 || c_fill !== '0) begin
            errors++;
            $display("FAIL down_after got v=%b fill=%0d want 0 0", c_out_valid, c_fill);
        end
        c_in_valid = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            c_in_data = 32'(cyc);
            #1;
            if (c_in_ready) acc_cyc.push_back(cyc);
            tick;
        end
        c_in_valid = 1'b0;
        checks++;
        if (acc_cyc.size() < 6) begin
            errors++;
            $display("FAIL down_rate_count got %0d want >=6", acc_cyc.size());
        end
        for (int i = 1; i + 1 < acc_cyc.size(); i++) begin
            checks++;
            if (acc_cyc[i+1] - acc_cyc[i] != 4) begin
                errors++;
                $display("FAIL down_rate_gap i=%0d got %0d want 4",
                         i, acc_cyc[i+1] - acc_cyc[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [11:0] pre [2];
        logic [11:0] post [3];
        pre = '{12'h111, 12'h222};
        post = '{12'h123, 12'h456, 12'h789};
        a_out_ready = 1'b0;
        a_in_last = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_in_data = pre[i];
            a_in_valid = 1'b1;
            #1;
            tick;
        end
        a_in_valid = 1'b0;
        #1;
        checks++;
        if (a_fill !== 6'd24) begin
            errors++;
            $display("FAIL rstmid_pre got fill=%0d want 24", a_fill);
        end
        rst_n = 1'b0;
        a_in_valid = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ready got %b want 0", a_in_ready);
        end
        tick;
        rst_n = 1'b1;
        a_in_valid = 1'b0;
        #1;
        checks++;
        if (a_fill !== '0 || a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_clear got fill=%0d v=%b want 0 0", a_fill, a_out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            a_in_data = post[i];
            a_in_valid = 1'b1;
            #1;
            tick;
        end
        a_in_valid = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 25'h1456123 || a_out_nbits !== 5'd25) begin
            errors++;
            $display("FAIL rstmid_word got v=%b d=%h nb=%0d want 1 1456123 25",
                     a_out_valid, a_out_data, a_out_nbits);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_packet_end;
        test_exact_multiple;
        test_downsize;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
